// File: rtl/ob_pkg.sv
// Shared types for the order-book command scheduler: op codes, scheduler
// states and the command record seen by the orderbook.
package ob_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_DATA_SIZE     = 64;
    localparam int DEF_FIFO_SIZE     = 64;
    localparam int DEF_PRICE_LEVELS  = 256;
    localparam int DEF_MAX_QUEUES    = 1024;
    localparam int DEF_MATCH_TIMEOUT = 255;

    localparam int OB_IDX_W   = $clog2(DEF_FIFO_SIZE);
    localparam int OB_PRICE_W = $clog2(DEF_PRICE_LEVELS);
    localparam int OB_QID_W   = $clog2(DEF_MAX_QUEUES);

    typedef enum logic [2:0] {
        OP_IDLE   = 3'b000,
        OP_ADD    = 3'b100,
        OP_MATCH  = 3'b101,
        OP_REMOVE = 3'b110,
        OP_MODIFY = 3'b111
    } ob_op_e;

    typedef enum logic {
        IDLE       = 1'b0,
        MATCH_WAIT = 1'b1
    } sched_state_e;

    typedef struct packed {
        ob_op_e                  op;
        logic                    side;
        logic [OB_PRICE_W-1:0]   price;
        logic [OB_QID_W-1:0]     q_index;
        logic [OB_IDX_W-1:0]     index;
        logic [DEF_DATA_SIZE-1:0] data;
    } ob_cmd_t;

    // Every forwardable op has the top bit set; 001/010/011 are malformed.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ob_cmd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping N-1 -> 0) wins.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    always_comb begin
        int   w_j;
        logic w_found;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && req[w_j]) begin
                w_found      = 1'b1;
                grant[w_j]   = 1'b1;
                grant_idx    = ID_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/ob_cmd_sched.sv
// Round-robin scheduler feeding the single orderbook command port; holds all
// traffic off while a match op is being processed by the orderbook.
module ob_cmd_sched
    import ob_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int FIFO_SIZE     = DEF_FIFO_SIZE,
    parameter int PRICE_LEVELS  = DEF_PRICE_LEVELS,
    parameter int MAX_QUEUES    = DEF_MAX_QUEUES,
    parameter int MATCH_TIMEOUT = DEF_MATCH_TIMEOUT,
    localparam int IDX_W   = $clog2(FIFO_SIZE),
    localparam int PRICE_W = $clog2(PRICE_LEVELS),
    localparam int QID_W   = $clog2(MAX_QUEUES),
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*3-1:0]         req_op_flag,
    input  logic [NUM_REQ-1:0]           req_side,
    input  logic [NUM_REQ*PRICE_W-1:0]   req_price,
    input  logic [NUM_REQ*QID_W-1:0]     req_q_index,
    input  logic [NUM_REQ*IDX_W-1:0]     req_index,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    input  logic                         ob_busy,
    output logic [2:0]                   ob_op_flag,
    output logic                         ob_side,
    output logic [PRICE_W-1:0]           ob_price,
    output logic [QID_W-1:0]             ob_q_index,
    output logic [IDX_W-1:0]             ob_index,
    output logic [DATA_SIZE-1:0]         ob_data,
    output logic [ID_W-1:0]              grant_id,
    output logic                         sched_busy,
    output logic                         bad_op,
    output logic                         match_timeout
);

    localparam int WC_W = $clog2(MATCH_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX   = WC_W'(MATCH_TIMEOUT);
    localparam logic [ID_W-1:0] LAST_REQ = ID_W'(NUM_REQ - 1);

    sched_state_e          r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [WC_W-1:0]       r_wait_cnt;
    logic [2:0]            r_op;
    logic                  r_side;
    logic [PRICE_W-1:0]    r_price;
    logic [QID_W-1:0]      r_q_index;
    logic [IDX_W-1:0]      r_index;
    logic [DATA_SIZE-1:0]  r_data;
    logic [ID_W-1:0]       r_grant_id;
    logic                  r_bad_op;

    logic [NUM_REQ-1:0]    w_eff;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_win;
    logic [ID_W-1:0]       w_next_ptr;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_release;
    logic                  w_timeout;
    logic [2:0]            w_sel_op;
    logic                  w_sel_side;
    logic [PRICE_W-1:0]    w_sel_price;
    logic [QID_W-1:0]      w_sel_q_index;
    logic [IDX_W-1:0]      w_sel_index;
    logic [DATA_SIZE-1:0]  w_sel_data;

    // Op 000 is "nothing to send" even when valid is high, so it never competes.
    always_comb begin
        w_eff = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eff[i] = req_valid[i] && (req_op_flag[i*3 +: 3] != OP_IDLE);
        end
    end

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req       (w_eff),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_win)
    );

    // Gating with reset keeps ready low for the whole time reset is held.
    assign w_can_accept = reset && (r_state == IDLE) && !ob_busy;
    assign req_ready    = w_can_accept ? w_grant : '0;
    assign w_accept     = |req_ready;
    assign w_next_ptr   = (w_win == LAST_REQ) ? '0 : (w_win + 1'b1);

    always_comb begin
        w_sel_op      = req_op_flag[int'(w_win)*3 +: 3];
        w_sel_side    = req_side[w_win];
        w_sel_price   = req_price[int'(w_win)*PRICE_W +: PRICE_W];
        w_sel_q_index = req_q_index[int'(w_win)*QID_W +: QID_W];
        w_sel_index   = req_index[int'(w_win)*IDX_W +: IDX_W];
        w_sel_data    = req_data[int'(w_win)*DATA_SIZE +: DATA_SIZE];
    end

    // The first MATCH_WAIT cycle always waits, since ob_busy lags the 101 by a cycle.
    assign w_release = (r_state == MATCH_WAIT) && (r_wait_cnt != '0) && !ob_busy;
    assign w_timeout = (r_state == MATCH_WAIT) && !w_release && (r_wait_cnt == WC_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
            r_op       <= OP_IDLE;
            r_side     <= 1'b0;
            r_price    <= '0;
            r_q_index  <= '0;
            r_index    <= '0;
            r_data     <= '0;
            r_grant_id <= '0;
            r_bad_op   <= 1'b0;
        end else begin
            r_op     <= OP_IDLE;
            r_bad_op <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_grant_id <= w_win;
                        r_side     <= w_sel_side;
                        r_price    <= w_sel_price;
                        r_q_index  <= w_sel_q_index;
                        r_index    <= w_sel_index;
                        r_data     <= w_sel_data;
                        r_op       <= op_is_legal(w_sel_op) ? w_sel_op : OP_IDLE;
                        r_bad_op   <= !op_is_legal(w_sel_op);
                        if (w_sel_op == OP_MATCH) begin
                            r_state    <= MATCH_WAIT;
                            r_wait_cnt <= '0;
                        end
                    end
                end
                MATCH_WAIT: begin
                    if (r_wait_cnt != WC_MAX) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                    if (w_release || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ob_op_flag    = r_op;
    assign ob_side       = r_side;
    assign ob_price      = r_price;
    assign ob_q_index    = r_q_index;
    assign ob_index      = r_index;
    assign ob_data       = r_data;
    assign grant_id      = r_grant_id;
    assign sched_busy    = (r_state == MATCH_WAIT);
    assign bad_op        = r_bad_op;
    assign match_timeout = w_timeout;

endmodule

// File: tb/tb_ob_cmd_sched.sv
// Directed bench for ob_cmd_sched: one default instance and one with a short
// match timeout, sharing command payloads but with their own valid/busy.
module tb_ob_cmd_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_valid_b;
    logic [11:0]  req_op_flag;
    logic [3:0]   req_side;
    logic [31:0]  req_price;
    logic [39:0]  req_q_index;
    logic [23:0]  req_index;
    logic [255:0] req_data;
    logic         ob_busy, ob_busy_b;

    logic [3:0]  ready_a, ready_b;
    logic [2:0]  op_a, op_b;
    logic        side_a, side_b;
    logic [7:0]  price_a, price_b;
    logic [9:0]  qi_a, qi_b;
    logic [5:0]  idx_a, idx_b;
    logic [63:0] data_a, data_b;
    logic [1:0]  gid_a, gid_b;
    logic        sbusy_a, sbusy_b;
    logic        bad_a, bad_b;
    logic        mto_a, mto_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ob_cmd_sched u_dut (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_ready (ready_a),
        .req_op_flag (req_op_flag), .req_side (req_side), .req_price (req_price),
        .req_q_index (req_q_index), .req_index (req_index), .req_data (req_data),
        .ob_busy (ob_busy),
        .ob_op_flag (op_a), .ob_side (side_a), .ob_price (price_a),
        .ob_q_index (qi_a), .ob_index (idx_a), .ob_data (data_a),
        .grant_id (gid_a), .sched_busy (sbusy_a), .bad_op (bad_a),
        .match_timeout (mto_a)
    );

    ob_cmd_sched #(.MATCH_TIMEOUT (8)) u_dut_to (
        .clk (clk), .reset (reset),
        .req_valid (req_valid_b), .req_ready (ready_b),
        .req_op_flag (req_op_flag), .req_side (req_side), .req_price (req_price),
        .req_q_index (req_q_index), .req_index (req_index), .req_data (req_data),
        .ob_busy (ob_busy_b),
        .ob_op_flag (op_b), .ob_side (side_b), .ob_price (price_b),
        .ob_q_index (qi_b), .ob_index (idx_b), .ob_data (data_b),
        .grant_id (gid_b), .sched_busy (sbusy_b), .bad_op (bad_b),
        .match_timeout (mto_b)
    );

    function automatic logic [63:0] pay(input int i);
        return 64'hDA7A_0000_0000_0000 | 64'(i * 32'h1111);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op);
        req_valid[i]          = v;
        req_op_flag[i*3 +: 3] = op;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        ob_busy     = 1'b0;
        ob_busy_b   = 1'b0;
        req_valid   = 4'hF;
        req_valid_b = 4'hF;
        req_side    = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            req_op_flag[i*3 +: 3]  = 3'b100;
            req_data[i*64 +: 64]   = pay(i);
            req_price[i*8 +: 8]    = 8'(8'h10 + i);
            req_q_index[i*10 +: 10] = 10'(10'h100 + i);
            req_index[i*6 +: 6]    = 6'(6'h20 + i);
        end
        #2 reset = 1'b0;
        #10;
        chk("rst_ready_a", 64'(ready_a), 64'h0);
        chk("rst_ready_b", 64'(ready_b), 64'h0);
        chk("rst_op_a", 64'(op_a), 64'h0);
        chk("rst_gid_a", 64'(gid_a), 64'h0);
        chk("rst_sbusy_a", 64'(sbusy_a), 64'h0);
        chk("rst_bad_a", 64'(bad_a), 64'h0);
        chk("rst_mto_a", 64'(mto_a), 64'h0);
        chk("rst_data_a", data_a, 64'h0);

        // Release reset: first grant goes to requester 0.
        cyc();
        reset       = 1'b1;
        req_valid_b = 4'h0;
        smp();
        chk("first_ready", 64'(ready_a), 64'h1);
        chk("first_op_idle", 64'(op_a), 64'h0);

        // Round robin with all four requesters valid.
        for (int k = 1; k <= 4; k++) begin
            cyc();
            smp();
            chk("rr_op", 64'(op_a), 64'h4);
            chk("rr_gid", 64'(gid_a), 64'(k - 1));
            chk("rr_data", data_a, pay(k - 1));
            chk("rr_side", 64'(side_a), 64'((k - 1) % 2));
            chk("rr_price", 64'(price_a), 64'(8'h10 + k - 1));
            chk("rr_ready", 64'(ready_a), 64'(4'b0001 << (k % 4)));
        end
        cyc();
        req_valid = 4'h0;
        smp();
        chk("rr_wrap_gid", 64'(gid_a), 64'h0);
        chk("rr_wrap_data", data_a, pay(0));
        chk("rr_wrap_qidx", 64'(qi_a), 64'h100);
        chk("rr_wrap_idx", 64'(idx_a), 64'h20);
        cyc();
        smp();
        chk("op_back_idle", 64'(op_a), 64'h0);

        // Match hold-off: req1 issues 101 in T, ptr is 1.
        cyc();
        set_req(0, 1'b1, 3'b100);
        set_req(1, 1'b1, 3'b101);
        set_req(2, 1'b1, 3'b100);
        smp();
        chk("match_ready_T", 64'(ready_a), 64'h2);
        cyc();
        req_valid[1] = 1'b0;
        smp();
        chk("match_op_T1", 64'(op_a), 64'h5);
        chk("match_gid_T1", 64'(gid_a), 64'h1);
        chk("match_sbusy_T1", 64'(sbusy_a), 64'h1);
        chk("match_ready_T1", 64'(ready_a), 64'h0);
        for (int t = 2; t <= 10; t++) begin
            cyc();
            if (t == 2)  ob_busy = 1'b1;
            if (t == 10) ob_busy = 1'b0;
            smp();
            chk("hold_ready", 64'(ready_a), 64'h0);
            chk("hold_sbusy", 64'(sbusy_a), 64'h1);
            if (t == 2) chk("hold_op_T2", 64'(op_a), 64'h0);
        end
        cyc();
        smp();
        chk("resume_ready_T11", 64'(ready_a), 64'h4);
        chk("resume_sbusy_T11", 64'(sbusy_a), 64'h0);
        cyc();
        req_valid = 4'h0;
        smp();
        chk("resume_op", 64'(op_a), 64'h4);
        chk("resume_gid", 64'(gid_a), 64'h2);
        chk("resume_data", data_a, pay(2));

        // Illegal op from req0 and idle op from req2; ptr is 3.
        cyc();
        set_req(0, 1'b1, 3'b011);
        set_req(2, 1'b1, 3'b000);
        smp();
        chk("bad_ready", 64'(ready_a), 64'h1);
        cyc();
        req_valid[0] = 1'b0;
        smp();
        chk("bad_pulse", 64'(bad_a), 64'h1);
        chk("bad_op_fwd", 64'(op_a), 64'h0);
        chk("bad_gid", 64'(gid_a), 64'h0);
        chk("idle_op_ready", 64'(ready_a), 64'h0);
        for (int t = 0; t < 2; t++) begin
            cyc();
            smp();
            chk("bad_pulse_end", 64'(bad_a), 64'h0);
            chk("idle_op_never", 64'(ready_a), 64'h0);
        end
        cyc();
        req_valid = 4'h0;

        // Async reset mid-MATCH_WAIT; ptr is 1.
        set_req(1, 1'b1, 3'b101);
        smp();
        chk("ar_ready", 64'(ready_a), 64'h2);
        cyc();
        req_valid = 4'h0;
        ob_busy   = 1'b1;
        smp();
        chk("ar_sbusy_pre", 64'(sbusy_a), 64'h1);
        chk("ar_op_pre", 64'(op_a), 64'h5);
        #2;
        ob_busy = 1'b0;
        set_req(1, 1'b1, 3'b100);
        set_req(3, 1'b1, 3'b100);
        reset = 1'b0;
        #1;
        chk("ar_sbusy", 64'(sbusy_a), 64'h0);
        chk("ar_op", 64'(op_a), 64'h0);
        chk("ar_gid", 64'(gid_a), 64'h0);
        chk("ar_ready_in_rst", 64'(ready_a), 64'h0);
        cyc();
        reset = 1'b1;
        smp();
        chk("ar_ptr_cleared", 64'(ready_a), 64'h2);
        cyc();
        req_valid = 4'h0;
        smp();
        chk("ar_post_op", 64'(op_a), 64'h4);
        chk("ar_post_gid", 64'(gid_a), 64'h1);

        // Timeout on the MATCH_TIMEOUT=8 instance, ob_busy held high.
        cyc();
        req_valid_b = 4'h1;
        req_op_flag[2:0] = 3'b101;
        smp();
        chk("to_ready", 64'(ready_b), 64'h1);
        cyc();
        req_valid_b = 4'h0;
        ob_busy_b   = 1'b1;
        smp();
        chk("to_op_entry", 64'(op_b), 64'h5);
        chk("to_sbusy_entry", 64'(sbusy_b), 64'h1);
        chk("to_mto_entry", 64'(mto_b), 64'h0);
        for (int e = 1; e <= 8; e++) begin
            cyc();
            smp();
            chk("to_pulse", 64'(mto_b), 64'(e == 8));
            chk("to_sbusy", 64'(sbusy_b), 64'h1);
        end
        cyc();
        req_valid_b = 4'h1;
        req_op_flag[2:0] = 3'b100;
        smp();
        chk("to_pulse_end", 64'(mto_b), 64'h0);
        chk("to_back_idle", 64'(sbusy_b), 64'h0);
        chk("busy_idle_ready", 64'(ready_b), 64'h0);
        cyc();
        smp();
        chk("busy_idle_op", 64'(op_b), 64'h0);
        cyc();
        ob_busy_b = 1'b0;
        smp();
        chk("to_resume_ready", 64'(ready_b), 64'h1);
        cyc();
        req_valid_b = 4'h0;
        smp();
        chk("to_resume_op", 64'(op_b), 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
